// File: rtl/dmem_responder_pkg.sv
// Shared CPU-side constants and types for the data-memory responder.
// Holds the FSM state encoding and the default geometry/latency values.
package dmem_responder_pkg;

  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_ADDR_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_array.sv
// Word-organised data storage: byte-enabled synchronous write, asynchronous read.
// Contents are deliberately not reset so a preloaded image survives rst.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: accepts one access in IDLE, inserts
// WAIT_CYCLES wait states, commits stores and strobes a one-cycle response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              stall
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              in_idle;
  logic              enter_resp;
  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_wdata;
  logic [3:0]        eff_be;
  logic [31:0]       mem_rdata;
  logic              wr_en;

  // With zero wait states the access completes on the accept edge itself,
  // so the live request fields are used instead of the latched copies.
  assign in_idle   = (state_q == ST_IDLE);
  assign eff_we    = in_idle ? req_we    : we_q;
  assign eff_addr  = in_idle ? req_addr  : addr_q;
  assign eff_wdata = in_idle ? req_wdata : wdata_q;
  assign eff_be    = in_idle ? req_be    : be_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    enter_resp  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            cnt_d      = 4'd0;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = eff_we ? 32'h0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Reset held across an edge must not let a pending store land.
  assign wr_en = enter_resp & eff_we & ~rst;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (eff_addr),
    .wr_data (eff_wdata),
    .wr_be   (eff_be),
    .rd_addr (eff_addr),
    .rd_data (mem_rdata)
  );

  assign req_ready = in_idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign stall     = req_valid & ~rsp_valid_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (0..15).
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width (1K x 32 storage).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  MEM-stage access request, held until rsp_valid.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  ADDR_W  word address (ALU result bits [11:2]).
REQ-008 SHALL have port req_wdata  input  32  store data (rt value).
REQ-009 SHALL have port req_be  input  4  byte-lane write enables, bit i = bits [8i+7:8i].
REQ-010 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata  output  32  load data, valid when rsp_valid.
REQ-013 SHALL have port stall  output  1  pipeline freeze request to IF/ID, ID/EX, EX/MEM, PC.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL assert req_ready only in IDLE; accept occurs on an edge where req_valid & req_ready.
REQ-016 SHALL on accept latch req_we, req_addr, req_wdata, req_be; later input changes have no effect on the pending access.
REQ-017 SHALL on accept go IDLE->WAIT and load a 4-bit counter with WAIT_CYCLES-1; if WAIT_CYCLES=0 go IDLE->RESP directly.
REQ-018 SHALL in WAIT decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-019 SHALL commit a store on the edge entering RESP, writing only lanes with be set; be=4'b0000 is a no-op store that still responds.
REQ-020 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE unconditionally.
REQ-021 SHALL drive rsp_rdata in RESP with the addressed word (loads) and 32'h0 (stores); 32'h0 outside RESP.
REQ-022 SHALL give response latency WAIT_CYCLES+1 cycles from accept edge to rsp_valid cycle.
REQ-023 SHALL drive stall = req_valid & ~rsp_valid (combinational); no request -> no stall.
REQ-024 SHALL use only the low ADDR_W address bits; address all-ones is a valid word, no wrap to other storage.
REQ-025 SHALL return the newly written data for a load issued back-to-back after a store to the same address.
REQ-026 SHALL not accept a new request in the RESP cycle; earliest next accept is the cycle after RESP (IDLE).

Reset
REQ-027 SHALL on rst force state IDLE, counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, stall per REQ-023.
REQ-028 SHALL on rst mid-access discard the pending access; no store commits, no response issues.
REQ-029 SHALL not reset storage contents; storage is loadable via $readmemh by the testbench.

Structure
REQ-030 SHALL place the state encoding and default WAIT_CYCLES/ADDR_W constants in the shared CPU package.
REQ-031 SHALL instantiate one sub-module dmem_array: 2^ADDR_W x 32 storage, synchronous byte-enabled write, asynchronous read.

Verification
REQ-032 Load: preload word 5 = 32'hDEADBEEF, WAIT_CYCLES=2, load addr 5 -> rsp_valid in cycle 3 after accept, rsp_rdata 32'hDEADBEEF, stall high for 3 cycles.
REQ-033 Byte store: word 7 = 32'h11223344, store 32'hAABBCCDD be=4'b0101, then load 7 -> 32'h11BB33DD.
REQ-034 Zero wait: WAIT_CYCLES=0, store 32'h12345678 to addr 1023 then load 1023 -> rsp_valid 1 cycle after each accept, data 32'h12345678.
REQ-035 Reset mid-op: store 32'hCAFEF00D to addr 3 (old 0), rst pulse during WAIT -> no rsp_valid, req_ready 1, later load 3 returns 32'h0.
REQ-036 Back-to-back: req_valid held with 4 sequential loads addr 0..3 -> exactly 4 rsp_valid pulses, one accept per IDLE, no accept during RESP.
